// File: rtl/full_adder_sync.sv
// ---------------------------------------------------------------------------
// full_adder_sync
//
// Registered 1-bit full adder. It is the arithmetic core of an LSB-first
// bit-serial adder. On each rising edge of phi, the block registers the sum
// bit and the carry-out of (a, b, cin). The external sequencer feeds c_out
// back as cin for the next bit, and drives cin=0 on bit 0. This block never
// feeds the carry back internally.
//
// Optional feature, enabled by defining FULLADDERSYNC_WORD_ASSEMBLY_EN:
//   The serial sum bits are collected into a parallel word, sum_word.
//   word_valid pulses for one cycle after the last bit of each word.
//   When the macro is undefined, sum_word and word_valid are tied to 0 and
//   no assembly registers exist.
//
// Parameters:
//   WIDTH      serial word length in bits (legal range 2..64). It sets the
//              bit-counter wrap point and the width of sum_word.
//
// Ports:
//   a          in   1      operand A bit, LSB first
//   b          in   1      operand B bit, LSB first
//   cin        in   1      carry-in bit
//   phi        in   1      clock, rising-edge active
//   y          out  1      registered sum bit
//   c_out      out  1      registered carry-out bit
//   rst_n      in   1      asynchronous active-low reset
//   sum_word   out  WIDTH  assembled sum word (optional feature)
//   word_valid out  1      one-cycle pulse: sum_word is complete
//                          (optional feature)
// ---------------------------------------------------------------------------
module full_adder_sync #(
  parameter int WIDTH = 32
) (
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             phi,
  output logic             y,
  output logic             c_out,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum_word,
  output logic             word_valid
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Single-bit sum: odd parity of the three inputs.
  function automatic logic full_sum(input logic fa, input logic fb, input logic fc);
    return fa ^ fb ^ fc;
  endfunction

  // Carry: majority of the three inputs.
  function automatic logic full_carry(input logic fa, input logic fb, input logic fc);
    return (fa & fb) | (fa & fc) | (fb & fc);
  endfunction

  logic             sum_bit;
  logic             carry_bit;
  logic             sum_p0;
  logic             carry_p0;
  logic [CNT_W-1:0] bit_cnt;

  always_comb begin
    sum_bit   = full_sum(a, b, cin);
    carry_bit = full_carry(a, b, cin);
  end

  // Stage p0: registered sum and carry. This is the only path from the
  // inputs to y/c_out.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      sum_p0   <= 1'b0;
      carry_p0 <= 1'b0;
    end else begin
      sum_p0   <= sum_bit;
      carry_p0 <= carry_bit;
    end
  end

  assign y     = sum_p0;
  assign c_out = carry_p0;

  // The bit position advances on every edge, independent of the data.
  // A reset mid-word realigns the counter to bit 0.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (bit_cnt == LAST_BIT) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef FULLADDERSYNC_WORD_ASSEMBLY_EN
  logic [WIDTH-1:0] word_p0;
  logic             vld_p0;

  // Stage p0: word assembly. Only the addressed bit is written on each
  // edge. The finished word therefore stays intact until the next word's
  // bit 0 overwrites it.
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      word_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      word_p0[bit_cnt] <= sum_bit;
      vld_p0           <= (bit_cnt == LAST_BIT);
    end
  end

  assign sum_word   = word_p0;
  assign word_valid = vld_p0;
`else
  assign sum_word   = '0;
  assign word_valid = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_sync.sv
module tb_full_adder_sync;

  localparam int W = 32;

  logic         phi = 1'b0;
  logic         rst_n = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         cin = 1'b0;
  logic         y;
  logic         c_out;
  logic [W-1:0] sum_word;
  logic         word_valid;

  int checks = 0;
  int errors = 0;

  always #5 phi = ~phi;

  full_adder_sync #(.WIDTH(W)) dut (
    .a(a), .b(b), .cin(cin), .phi(phi), .y(y), .c_out(c_out),
    .rst_n(rst_n), .sum_word(sum_word), .word_valid(word_valid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Puts the DUT in reset. Returns at a falling edge with rst_n already
  // released, so the caller can drive bit 0 before the next rising edge.
  task automatic apply_reset();
    @(negedge phi);
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0;
    @(negedge phi);
    @(negedge phi);
    rst_n = 1'b1;
  endtask

  // Behaves like the serial sequencer: LSB first, cin=0 on bit 0, then the
  // previous c_out as cin. Collects the y bits and the word_valid history.
  task automatic run_word(input logic [W-1:0] x, input logic [W-1:0] z,
                          output logic [W-1:0] s, output logic cf,
                          output logic [W-1:0] wv);
    for (int i = 0; i < W; i++) begin
      a   = x[i];
      b   = z[i];
      cin = (i == 0) ? 1'b0 : c_out;
      @(posedge phi);
      @(negedge phi);
      s[i]  = y;
      wv[i] = word_valid;
    end
    cf = c_out;
  endtask

  task automatic test_reset();
    a = 1'b1; b = 1'b1; cin = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge phi);
      checks++;
      if (y !== 1'b0 || c_out !== 1'b0 || word_valid !== 1'b0 || sum_word !== '0) begin
        errors++;
        $display("FAIL reset_hold: y=%b c=%b wv=%b sw=%h, expected all 0", y, c_out, word_valid, sum_word);
      end
    end
    rst_n = 1'b1;
    @(posedge phi);
    @(negedge phi);
    checks++;
    if (y !== 1'b1 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: y=%b c=%b, expected y=1 c=1", y, c_out);
    end
    // The reset is asynchronous, so the outputs must clear with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 1'b0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: y=%b c=%b, expected 0 0", y, c_out);
    end
    @(negedge phi);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    int         n;
    for (int i = 0; i < 40; i++) begin
      v = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
      a = v[2]; b = v[1]; cin = v[0];
      n = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(posedge phi);
      @(negedge phi);
      checks++;
      if (y !== 1'((n % 2)) || c_out !== 1'((n / 2))) begin
        errors++;
        $display("FAIL truth_%b: y=%b c=%b, expected y=%0d c=%0d", v, y, c_out, n % 2, n / 2);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge phi);
    a = 1'b1; b = 1'b1; cin = 1'b0;
    @(posedge phi);
    @(negedge phi);
    #1 a = 1'b0; b = 1'b0; cin = 1'b1;
    #2;
    checks++;
    if (y !== 1'b0 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL hold_low: y=%b c=%b, expected y=0 c=1", y, c_out);
    end
    @(posedge phi);
    #2 a = 1'b1; b = 1'b1; cin = 1'b1;
    @(negedge phi);
    checks++;
    if (y !== 1'b1 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_high: y=%b c=%b, expected y=1 c=0", y, c_out);
    end
  endtask

  // Checks one serial word against plain integer addition.
  task automatic check_word(input string tag, input logic [W-1:0] x, input logic [W-1:0] z,
                            input logic [W-1:0] s, input logic cf, input logic [W-1:0] wv);
    logic [W:0] expv;
    expv = {1'b0, x} + {1'b0, z};
    checks++;
    if (s !== expv[W-1:0] || cf !== expv[W]) begin
      errors++;
      $display("FAIL %s_sum: y bits=%h c=%b, expected %h c=%b", tag, s, cf, expv[W-1:0], expv[W]);
    end
`ifdef FULLADDERSYNC_WORD_ASSEMBLY_EN
    checks++;
    if (sum_word !== expv[W-1:0] || wv !== {1'b1, {(W-1){1'b0}}}) begin
      errors++;
      $display("FAIL %s_word: sum_word=%h wv=%h, expected %h wv=80000000", tag, sum_word, wv, expv[W-1:0]);
    end
`else
    checks++;
    if (sum_word !== '0 || wv !== '0) begin
      errors++;
      $display("FAIL %s_tied: sum_word=%h wv=%h, expected 0 0", tag, sum_word, wv);
    end
`endif
  endtask

  task automatic test_serial();
    logic [W-1:0] s, wv;
    logic         cf;
    apply_reset();
    run_word(32'h0000FFFF, 32'h00000001, s, cf, wv);
    check_word("ser_ffff", 32'h0000FFFF, 32'h00000001, s, cf, wv);
    run_word(32'hFFFFFFFF, 32'h00000001, s, cf, wv);
    check_word("ser_wrap", 32'hFFFFFFFF, 32'h00000001, s, cf, wv);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, wv, x, z;
    logic         cf;
    apply_reset();
    run_word(32'h12345678, 32'h11111111, s, cf, wv);
    check_word("b2b_fixed", 32'h12345678, 32'h11111111, s, cf, wv);
    for (int k = 0; k < 4; k++) begin
      x = $urandom;
      z = $urandom;
      run_word(x, z, s, cf, wv);
      check_word($sformatf("b2b_rand%0d", k), x, z, s, cf, wv);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s, wv, x, z;
    logic         cf;
    apply_reset();
    for (int i = 0; i <= 10; i++) begin
      a = 1'b1; b = 1'b1;
      cin = (i == 0) ? 1'b0 : c_out;
      @(posedge phi);
      @(negedge phi);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 1'b0 || c_out !== 1'b0 || sum_word !== '0 || word_valid !== 1'b0 || dut.bit_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: y=%b c=%b sw=%h wv=%b cnt=%0d, expected all 0",
               y, c_out, sum_word, word_valid, dut.bit_cnt);
    end
    @(negedge phi);
    rst_n = 1'b1;
    x = $urandom;
    z = $urandom;
    run_word(x, z, s, cf, wv);
    check_word("mid_after", x, z, s, cf, wv);
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_serial();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
